mul_result_stage: RTL and testbench
===================================

# mul_result_stage

Pipelined carry-propagate stage placed directly downstream of the 33-input Wallace column compressors in the multiplier. It captures the per-column sum and carry vectors produced by the 128 compressor columns, resolves them into a 128-bit product, and selects the RV64 result: low, high or word-sign-extended. A valid/ready handshake on both sides lets the multiplier stall against writeback. A synchronous flush supports pipeline kills.

## Interface
Parameters:
- XLEN, 64, result width; the product width is 2*XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  upstream has a compressed product.
- in_ready  out  1  stage can accept this cycle.
- s_vec  in  2*XLEN  column sum bits; bit i has weight 2^i.
- c_vec  in  2*XLEN  column carry-out bits; bit i has weight 2^(i+1), and bit 2*XLEN-1 is discarded.
- mul_hi  in  1  select product[2*XLEN-1:XLEN].
- is_w  in  1  word op: result is product[31:0] sign-extended. Ignored when mul_hi=1.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- result  out  XLEN  selected result.

## Operation
- Product: s_vec + (c_vec << 1), taken mod 2^(2*XLEN).
- Result select, in priority order:
  - mul_hi → product[127:64].
  - is_w → {32{product[31]}, product[31:0]}.
  - otherwise → product[63:0].
- A transfer on either port occurs on a clock edge where valid and ready are both 1.
- Split mode has two stages:
  - S1 registers lo = s[63:0] + {c[62:0],1'b0} as a 65-bit value (64-bit sum plus carry-out lo_co). It also registers s[127:64], c[126:63], mul_hi and is_w.
  - S2 computes hi = s_hi + c_hi + lo_co, applies the result select and registers result.
  - out_valid is the S2 valid flag.
- Stage advance:
  - S2 loads when it is empty or out_ready=1.
  - S1 loads when it is empty or S1 is moving into S2.
  - in_ready = !flush && (!s1_v || s2_load).
- Full: with S1 and S2 both held and out_ready=0, in_ready=0. No entry is dropped or duplicated, and order is strictly FIFO.
- Simultaneous events: an output transfer and an input transfer in the same cycle both complete, giving full throughput of 1 per cycle.
- Flush: on the edge where flush=1, all valid flags clear, in_ready=0 and in_valid is ignored. result keeps its last value.
- Reset: s1_v=0, s2_v=0, result=0, out_valid=0. in_ready=1 once rst_n=1 and flush=0.
- Reset mid-operation: any in-flight entries are lost with no partial output. The reset takes effect asynchronously on the rst_n fall.
- result holds stable while out_valid=1 and out_ready=0.

## Timing
- Split mode:
  - Accept at edge k gives out_valid=1 after edge k+1. Latency is 2 edges from in transfer to visible result: S1 at k, S2 at k+1.
  - Critical path is one 64-bit add plus carry-in per stage.
- Unsplit mode: latency is 1 edge. The full 128-bit add and the result select happen before the single result register.
- in_ready is combinational from out_ready and flush. There is no combinational path from in_valid to out_valid.
- Throughput is 1 per cycle in both modes when out_ready=1.

## Configuration
- MUL_RESULT_SPLIT_ADD_EN defined: two-stage split adder as described, latency 2.
- Undefined: single stage. S1 is removed, and in_ready = !flush && (!out_valid || out_ready). Latency 1, with identical results and handshake semantics.

## Test plan
- Basic add: s_vec=5, c_vec=3, mul_hi=0, is_w=0 → result=0xB after 2 edges (split) or 1 edge (unsplit).
- Half-boundary carry: s_vec=0xFFFF_FFFF_FFFF_FFFF, c_vec=1.
  - mul_hi=1 → result=1.
  - Same vectors with mul_hi=0 → result=1.
- Word sign-extend: s_vec=0x8000_0000, c_vec=0, is_w=1 → result=0xFFFF_FFFF_8000_0000. With mul_hi=1 as well → result=0.
- Back-pressure: send 4 back-to-back products A..D while holding out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepted (split mode).
  - After release, the results emerge in order A, B, C, D with no gaps once unblocked.
- Flush: 2 entries in flight, flush=1 for one cycle with in_valid=1 → out_valid=0 next cycle and the flush-cycle input is not accepted. A following product is processed normally.
- Reset: rst_n low mid-transfer with out_valid=1 → out_valid=0 and result=0 immediately. After release, in_ready=1 and a new product returns the correct value.

Source files
------------

// File: rtl/mul_result_stage.sv
// mul_result_stage: carry-propagate stage behind the Wallace column compressors.
// Resolves the column sum/carry vectors into the 2*XLEN-bit product and selects
// the RV64 result (low, high or sign-extended word) behind a valid/ready pair.
// Build option: define MUL_RESULT_SPLIT_ADD_EN for a two-stage split adder
// (latency 2). The default build uses a single stage with the full-width add
// (latency 1). Results and handshake behaviour are the same in both builds.
module mul_result_stage #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*XLEN-1:0] s_vec,
  input  logic [2*XLEN-1:0] c_vec,
  input  logic              mul_hi,
  input  logic              is_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result
);

  localparam int PW = 2 * XLEN;

  // High half wins over the word select; a word op sign-extends product[31:0].
  function automatic logic [XLEN-1:0] sel_result(input logic [PW-1:0] prod,
                                                 input logic          hi,
                                                 input logic          w);
    logic [XLEN-1:0] r;
    if (hi)     r = prod[PW-1:XLEN];
    else if (w) r = {{(XLEN-32){prod[31]}}, prod[31:0]};
    else        r = prod[XLEN-1:0];
    return r;
  endfunction

  logic            vld_p2;
  logic [XLEN-1:0] result_p2;
  logic            s2_load;
  logic            s2_vin;
  logic            s2_take;
  logic [XLEN-1:0] s2_din;
  logic            in_fire;

  // The top carry bit has weight 2^(2*XLEN) and falls off the product.
  logic            unused_c_msb;
  assign unused_c_msb = c_vec[PW-1];

  assign s2_load   = !vld_p2 || out_ready;
  assign out_valid = vld_p2;
  assign result    = result_p2;

`ifdef MUL_RESULT_SPLIT_ADD_EN
  logic            vld_p1;
  logic [XLEN:0]   lo_p1;
  logic [XLEN-1:0] s_hi_p1;
  logic [XLEN-1:0] c_hi_p1;
  logic            mul_hi_p1;
  logic            is_w_p1;
  logic [XLEN-1:0] hi_sum;

  assign in_ready = !flush && (!vld_p1 || s2_load);
  assign in_fire  = in_valid && in_ready;

  // ---- S1: low-half add, carry-out kept in lo_p1[XLEN] ----
  // S1 occupancy: refills whenever it is empty or draining into S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  vld_p1 <= 1'b0;
    else if (flush)              vld_p1 <= 1'b0;
    else if (!vld_p1 || s2_load) vld_p1 <= in_fire;
  end

  // S1 operands: low sum resolved now, high operands carried for S2.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      lo_p1     <= {1'b0, s_vec[XLEN-1:0]} + {1'b0, c_vec[XLEN-2:0], 1'b0};
      s_hi_p1   <= s_vec[PW-1:XLEN];
      c_hi_p1   <= c_vec[PW-2:XLEN-1];
      mul_hi_p1 <= mul_hi;
      is_w_p1   <= is_w;
    end
  end

  // ---- S2: high-half add with the low carry, then result select ----
  assign hi_sum  = s_hi_p1 + c_hi_p1 + {{(XLEN-1){1'b0}}, lo_p1[XLEN]};
  assign s2_din  = sel_result({hi_sum, lo_p1[XLEN-1:0]}, mul_hi_p1, is_w_p1);
  assign s2_vin  = vld_p1;
  assign s2_take = vld_p1 && s2_load && !flush;
`else
  assign in_ready = !flush && s2_load;
  assign in_fire  = in_valid && in_ready;

  // ---- single stage: full-width add and select ahead of the result register ----
  assign s2_din  = sel_result(s_vec + {c_vec[PW-2:0], 1'b0}, mul_hi, is_w);
  assign s2_vin  = in_fire;
  assign s2_take = in_fire;
`endif

  // Output register: valid follows the upstream slot, result only moves on a real load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
    end else begin
      if (flush)        vld_p2 <= 1'b0;
      else if (s2_load) vld_p2 <= s2_vin;
      if (s2_take)      result_p2 <= s2_din;
    end
  end

endmodule

// File: tb/tb_mul_result_stage.sv
// tb_mul_result_stage: randomized and directed checks of mul_result_stage
// against a queue-based reference model of the product/select rules.
module tb_mul_result_stage;

`ifdef MUL_RESULT_SPLIT_ADD_EN
  localparam int LAT   = 2;
  localparam int DEPTH = 2;
`else
  localparam int LAT   = 1;
  localparam int DEPTH = 1;
`endif

  typedef struct {
    logic [127:0] s;
    logic [127:0] c;
    logic         hi;
    logic         w;
  } txn_t;

  typedef struct {
    logic [63:0] res;
    int          age;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] s_vec;
  logic [127:0] c_vec;
  logic         mul_hi;
  logic         is_w;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  result;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t mq[$];

  mul_result_stage #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .s_vec(s_vec), .c_vec(c_vec), .mul_hi(mul_hi), .is_w(is_w),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input txn_t t);
    logic [127:0] p;
    p = t.s + (t.c << 1);
    if (t.hi)     return p[127:64];
    else if (t.w) return {{32{p[31]}}, p[31:0]};
    else          return p[63:0];
  endfunction

  function automatic txn_t mk(input logic [127:0] s, input logic [127:0] c,
                              input logic hi, input logic w);
    txn_t t;
    t.s = s; t.c = c; t.hi = hi; t.w = w;
    return t;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle: entered at posedge+1, drives inputs, checks outputs at the
  // falling edge against the model, advances the model on the rising edge.
  task automatic step(input logic iv, input txn_t t, input logic ordy, input logic fl,
                      output logic fi, output logic ov, output logic [63:0] res);
    logic exp_v, exp_r;
    ent_t e;
    in_valid = iv; s_vec = t.s; c_vec = t.c; mul_hi = t.hi; is_w = t.w;
    out_ready = ordy; flush = fl;
    @(negedge clk);
    exp_v = (mq.size() > 0) && (mq[0].age >= LAT - 1);
    exp_r = !fl && ((mq.size() < DEPTH) || ordy);
    check("in_ready", in_ready, exp_r);
    check("out_valid", out_valid, exp_v);
    if (exp_v) check("result", result, mq[0].res);
    ov  = out_valid;
    res = result;
    fi  = iv && exp_r;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (exp_v && ordy) void'(mq.pop_front());
      foreach (mq[i]) mq[i].age++;
      if (fi) begin
        e.res = ref_result(t);
        e.age = 0;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  // Single product with out_ready high; checks value and accept-to-output latency.
  task automatic send_one(input string tag, input txn_t t, input logic [63:0] exp);
    logic fi, ov;
    logic [63:0] res;
    int n;
    bit done;
    fi = 1'b0;
    for (int k = 0; k < 10 && !fi; k++) step(1'b1, t, 1'b1, 1'b0, fi, ov, res);
    if (!fi) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    done = 0;
    n = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      step(1'b0, t, 1'b1, 1'b0, fi, ov, res);
      n++;
      if (ov) begin
        done = 1;
        check({tag, "_val"}, res, exp);
        check({tag, "_lat"}, n, LAT);
      end
    end
    if (!done) check({tag, "_out_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    txn_t t, idle;
    txn_t bp[4];
    logic fi, ov;
    logic [63:0] res;
    int acc, outs, first_out, last_out, cyc;
    bit gap;

    idle = mk(128'd0, 128'd0, 1'b0, 1'b0);
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    s_vec = '0; c_vec = '0; mul_hi = 1'b0; is_w = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed products from the test plan.
    send_one("basic", mk(128'd5, 128'd3, 1'b0, 1'b0), 64'hB);
    send_one("carry_hi", mk(128'hFFFF_FFFF_FFFF_FFFF, 128'd1, 1'b1, 1'b0), 64'd1);
    send_one("carry_lo", mk(128'hFFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0), 64'd1);
    send_one("word_sext", mk(128'h8000_0000, 128'd0, 1'b0, 1'b1), 64'hFFFF_FFFF_8000_0000);
    send_one("word_hi", mk(128'h8000_0000, 128'd0, 1'b1, 1'b1), 64'd0);

    // Back-pressure: A..D offered back to back, out_ready low for 3 cycles.
    for (int i = 0; i < 4; i++) bp[i] = mk(rand128(), rand128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    acc = 0; outs = 0; first_out = -1; last_out = -1; gap = 0; cyc = 0;
    while ((outs < 4) && (cyc < 40)) begin
      step(acc < 4, (acc < 4) ? bp[acc] : idle, cyc >= 3, 1'b0, fi, ov, res);
      if (cyc == 2) check("bp_accepted_while_stalled", acc + (fi ? 1 : 0), DEPTH);
      if (ov && (cyc >= 3)) begin
        check("bp_order", res, ref_result(bp[outs]));
        if ((last_out >= 0) && (cyc != last_out + 1)) gap = 1;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        outs++;
      end
      if (fi) acc++;
      cyc++;
    end
    check("bp_all_out", outs, 4);
    check("bp_no_gaps", gap, 1'b0);

    // Flush with entries in flight and a valid input on the flush cycle.
    step(1'b1, mk(128'd11, 128'd1, 1'b0, 1'b0), 1'b0, 1'b0, fi, ov, res);
    step(1'b1, mk(128'd21, 128'd2, 1'b0, 1'b0), 1'b0, 1'b0, fi, ov, res);
    step(1'b1, mk(128'd31, 128'd3, 1'b0, 1'b0), 1'b0, 1'b1, fi, ov, res);
    check("flush_out_valid", out_valid, 1'b0);
    step(1'b0, idle, 1'b1, 1'b0, fi, ov, res);
    step(1'b0, idle, 1'b1, 1'b0, fi, ov, res);
    check("flush_drained", ov, 1'b0);
    send_one("after_flush", mk(128'd100, 128'd7, 1'b0, 1'b0), 64'd114);

    // Asynchronous reset while a result is held.
    t = mk(128'd40, 128'd1, 1'b0, 1'b0);
    step(1'b1, t, 1'b0, 1'b0, fi, ov, res);
    for (int k = 0; k < LAT; k++) step(1'b0, idle, 1'b0, 1'b0, fi, ov, res);
    check("rst_pre_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_result", result, 64'd0);
    mq.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    send_one("after_reset", mk(128'h1_0000_0000_0000_0000, 128'd3, 1'b1, 1'b0), 64'd1);

    // Randomized traffic with stalls and occasional flushes.
    for (int k = 0; k < 400; k++) begin
      t = mk(rand128(), rand128(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 3) == 0) t.s = {64'd0, t.s[63:0]};
      step($urandom_range(0, 3) != 0, t, $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0, fi, ov, res);
    end
    for (int k = 0; k < 6; k++) step(1'b0, idle, 1'b1, 1'b0, fi, ov, res);
    check("final_empty", mq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
